// File: rtl/vx_tcu_tfr_acc_chain.sv
// Multi-beat carry-save significand accumulator. Beats fold into a redundant
// accumulator; each group resolves in a FIN/OUT pipe to sign-magnitude.
module vx_tcu_tfr_acc_chain #(
  parameter int N    = 5,
  parameter int WI   = 26,
  parameter int WA   = 32,
  parameter int TAGW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              last_in,
  input  logic [TAGW-1:0]   tag_in,
  input  logic [N-2:0]      lane_mask,
  input  logic [N*WI-1:0]   sigs_in,
  input  logic [N-1:0]      sticky_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [WA-1:0]     sig_out,
  output logic              sticky_out,
  output logic [TAGW-1:0]   tag_out
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [WA-1:0]   acc_s_q, acc_s_d, acc_c_q, acc_c_d;
  logic            acc_sticky_q, acc_sticky_d;
  logic            fin_valid_q, fin_valid_d;
  logic [WA-1:0]   fin_s_q, fin_s_d, fin_c_q, fin_c_d;
  logic            fin_sticky_q, fin_sticky_d;
  logic [TAGW-1:0] fin_tag_q, fin_tag_d;
  logic            out_valid_q, out_valid_d;
  logic [WA-1:0]   out_sig_q, out_sig_d;
  logic            out_sticky_q, out_sticky_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;

  logic            first, accept, out_en, fin_en;
  logic [WA-1:0]   nxt_s, nxt_c;
  logic            nxt_sticky;
  logic [WA-1:0]   pos, neg_part;
  logic [WA-2:0]   neg_mag;

  function automatic logic [WA-1:0] sext(input logic [WI-1:0] v);
    return {{(WA-WI){v[WI-1]}}, v};
  endfunction

  // Returns {carry, sum} of a 3:2 compressor; carry is already weighted by 2.
  function automatic logic [2*WA-1:0] csa3(input logic [WA-1:0] a,
                                            input logic [WA-1:0] b,
                                            input logic [WA-1:0] x);
    logic [WA-1:0] s, c;
    s = a ^ b ^ x;
    c = ((a & b) | (a & x) | (b & x)) << 1;
    return {c, s};
  endfunction

  assign first  = (state_q == ST_IDLE);
  assign out_en = ~out_valid_q | ready_out;
  assign fin_en = ~fin_valid_q | out_en;
  assign ready_in = fin_en;
  assign accept = valid_in & ready_in;

  // NOTE: every always_comb variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    logic [2*WA-1:0] r;
    logic [WI-1:0]   lane;
    nxt_s = first ? '0 : acc_s_q;
    nxt_c = first ? '0 : acc_c_q;
    for (int i = 0; i < N-1; i++) begin
      lane  = lane_mask[i] ? sigs_in[i*WI +: WI] : '0;
      r     = csa3(nxt_s, nxt_c, sext(lane));
      nxt_s = r[WA-1:0];
      nxt_c = r[2*WA-1:WA];
    end
    // C-term only contributes on the opening beat of a group.
    lane  = first ? sigs_in[(N-1)*WI +: WI] : '0;
    r     = csa3(nxt_s, nxt_c, sext(lane));
    nxt_s = r[WA-1:0];
    nxt_c = r[2*WA-1:WA];
    nxt_sticky = (first ? 1'b0 : acc_sticky_q)
               | (|(sticky_in[N-2:0] & lane_mask))
               | (first & sticky_in[N-1]);
  end

  always_comb begin
    state_d      = state_q;
    acc_s_d      = acc_s_q;
    acc_c_d      = acc_c_q;
    acc_sticky_d = acc_sticky_q;
    if (accept) begin
      if (last_in) begin
        state_d      = ST_IDLE;
        acc_s_d      = '0;
        acc_c_d      = '0;
        acc_sticky_d = 1'b0;
      end else begin
        state_d      = ST_ACCUM;
        acc_s_d      = nxt_s;
        acc_c_d      = nxt_c;
        acc_sticky_d = nxt_sticky;
      end
    end
  end

  always_comb begin
    fin_valid_d  = fin_valid_q;
    fin_s_d      = fin_s_q;
    fin_c_d      = fin_c_q;
    fin_sticky_d = fin_sticky_q;
    fin_tag_d    = fin_tag_q;
    if (fin_en) begin
      fin_valid_d = accept & last_in;
      if (accept & last_in) begin
        fin_s_d      = nxt_s;
        fin_c_d      = nxt_c;
        fin_sticky_d = nxt_sticky;
        fin_tag_d    = tag_in;
      end
    end
  end

  // -2^(WA-1) negates to itself, giving magnitude 0 with the sign set.
  always_comb begin
    pos       = fin_s_q + fin_c_q;
    neg_part  = ~fin_s_q + ~fin_c_q + WA'(1);
    neg_mag   = neg_part[WA-2:0] + (WA-1)'(1);
    out_valid_d  = out_valid_q;
    out_sig_d    = out_sig_q;
    out_sticky_d = out_sticky_q;
    out_tag_d    = out_tag_q;
    if (out_en) begin
      out_valid_d = fin_valid_q;
      if (fin_valid_q) begin
        out_sig_d    = {pos[WA-1], pos[WA-1] ? neg_mag : pos[WA-2:0]};
        out_sticky_d = fin_sticky_q;
        out_tag_d    = fin_tag_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_s_q      <= '0;
      acc_c_q      <= '0;
      acc_sticky_q <= 1'b0;
      fin_valid_q  <= 1'b0;
      fin_s_q      <= '0;
      fin_c_q      <= '0;
      fin_sticky_q <= 1'b0;
      fin_tag_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sig_q    <= '0;
      out_sticky_q <= 1'b0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_s_q      <= acc_s_d;
      acc_c_q      <= acc_c_d;
      acc_sticky_q <= acc_sticky_d;
      fin_valid_q  <= fin_valid_d;
      fin_s_q      <= fin_s_d;
      fin_c_q      <= fin_c_d;
      fin_sticky_q <= fin_sticky_d;
      fin_tag_q    <= fin_tag_d;
      out_valid_q  <= out_valid_d;
      out_sig_q    <= out_sig_d;
      out_sticky_q <= out_sticky_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign valid_out  = out_valid_q;
  assign sig_out    = out_sig_q;
  assign sticky_out = out_sticky_q;
  assign tag_out    = out_tag_q;

endmodule

// File: tb/tb_vx_tcu_tfr_acc_chain.sv
// Bench for vx_tcu_tfr_acc_chain: integer reference sum per group feeds a
// scoreboard that is drained by an output monitor.
module tb_vx_tcu_tfr_acc_chain;
  localparam int N = 5, WI = 26, WA = 32, TAGW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in, ready_in, last_in;
  logic [TAGW-1:0]   tag_in;
  logic [N-2:0]      lane_mask;
  logic [N*WI-1:0]   sigs_in;
  logic [N-1:0]      sticky_in;
  logic              valid_out, ready_out, sticky_out;
  logic [WA-1:0]     sig_out;
  logic [TAGW-1:0]   tag_out;

  vx_tcu_tfr_acc_chain #(.N(N), .WI(WI), .WA(WA), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .last_in(last_in), .tag_in(tag_in), .lane_mask(lane_mask), .sigs_in(sigs_in),
    .sticky_in(sticky_in), .valid_out(valid_out), .ready_out(ready_out),
    .sig_out(sig_out), .sticky_out(sticky_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WA-1:0]   sig;
    logic            sticky;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rand_bp = 1'b0;

  logic          m_first = 1'b1;
  logic [WA-1:0] m_sum = '0;
  logic          m_stk = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WA-1:0] sx(input logic [WI-1:0] v);
    return {{(WA-WI){v[WI-1]}}, v};
  endfunction

  function automatic logic [WA-1:0] to_sm(input logic [WA-1:0] v);
    logic [WA-1:0] n;
    n = -v;
    return v[WA-1] ? {1'b1, n[WA-2:0]} : v;
  endfunction

  task automatic send_beat(input int l0, input int l1, input int l2, input int l3,
                           input int c, input logic [N-2:0] mask,
                           input logic [N-1:0] stk, input logic last,
                           input logic [TAGW-1:0] tag);
    int            waitc;
    logic [WA-1:0] sum;
    logic          s;
    logic [WI-1:0] ln [N];
    waitc = 0;
    ln[0] = WI'(l0); ln[1] = WI'(l1); ln[2] = WI'(l2); ln[3] = WI'(l3); ln[4] = WI'(c);
    @(negedge clk);
    valid_in  = 1'b1;
    sigs_in   = {ln[4], ln[3], ln[2], ln[1], ln[0]};
    lane_mask = mask;
    sticky_in = stk;
    last_in   = last;
    tag_in    = tag;
    #1;
    while (!ready_in && waitc < 200) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!ready_in) begin
      check("beat_accept_timeout", 64'(ready_in), 64'd1);
    end else begin
      @(posedge clk);
      sum = m_first ? '0 : m_sum;
      s   = m_first ? 1'b0 : m_stk;
      for (int i = 0; i < N-1; i++) begin
        if (mask[i]) begin
          sum = sum + sx(ln[i]);
          s   = s | stk[i];
        end
      end
      if (m_first) begin
        sum = sum + sx(ln[4]);
        s   = s | stk[4];
      end
      if (last) begin
        sb.push_back('{sig: to_sm(sum), sticky: s, tag: tag});
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
        m_sum   = sum;
        m_stk   = s;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: sample a settled cycle, just after the driving edge.
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1;
  logic [WA-1:0] prev_sig;
  logic          prev_stk;
  logic [TAGW-1:0] prev_tag;
  exp_t          e;
  always @(negedge clk) begin
    #1;
    if (!prev_reset && prev_valid && !prev_ready) begin
      check("hold_valid", 64'(valid_out), 64'd1);
      check("hold_sig", 64'(sig_out), 64'(prev_sig));
      check("hold_tag", 64'(tag_out), 64'(prev_tag));
      check("hold_sticky", 64'(sticky_out), 64'(prev_stk));
    end
    if (!reset && valid_out && ready_out) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(valid_out), 64'd0);
      end else begin
        e = sb.pop_front();
        check("sig_out", 64'(sig_out), 64'(e.sig));
        check("sticky_out", 64'(sticky_out), 64'(e.sticky));
        check("tag_out", 64'(tag_out), 64'(e.tag));
      end
    end
    prev_valid = valid_out;
    prev_ready = ready_out;
    prev_reset = reset;
    prev_sig   = sig_out;
    prev_stk   = sticky_out;
    prev_tag   = tag_out;
  end

  always @(negedge clk) begin
    if (rand_bp) ready_out = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ready_out = 1'b1; valid_in = 1'b0; last_in = 1'b0;
    tag_in = '0; lane_mask = '0; sigs_in = '0; sticky_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_sig_out", 64'(sig_out), 64'd0);
    check("rst_tag_out", 64'(tag_out), 64'd0);
    check("rst_sticky_out", 64'(sticky_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready_in", 64'(ready_in), 64'd1);

    // Single-beat group and its two-cycle latency
    send_beat(1, 2, 3, 4, 10, 4'hF, 5'b0, 1'b1, 32'h5);
    idle();
    #1;
    check("lat_fin_stage", 64'(valid_out), 64'd0);
    @(negedge clk);
    #1;
    check("lat_out_stage", 64'(valid_out), 64'd1);
    check("single_sig", 64'(sig_out), 64'h14);
    wait_drain("drain_single");

    // Two-beat group: C on the second beat must be ignored
    send_beat(5, 5, 5, 5, -3, 4'hF, 5'b0, 1'b0, 32'h6);
    send_beat(-10, 0, 0, 0, 100, 4'hF, 5'b0, 1'b1, 32'h7);
    idle();
    wait_drain("drain_two_beat");

    // Negative result, lane mask and sticky masking
    send_beat(-8, 7, 7, 7, 0, 4'b0001, 5'b00110, 1'b1, 32'h8);
    send_beat(-8, 7, 7, 7, 0, 4'b0001, 5'b10000, 1'b1, 32'h9);
    idle();
    wait_drain("drain_neg_mask");

    // Backpressure: FIN and OUT fill, ready_in drops, order preserved
    @(negedge clk);
    ready_out = 1'b0;
    send_beat(1, 0, 0, 0, 0, 4'hF, 5'b0, 1'b1, 32'h11);
    send_beat(2, 0, 0, 0, 0, 4'hF, 5'b0, 1'b1, 32'h12);
    idle();
    #1;
    check("bp_ready_low", 64'(ready_in), 64'd0);
    check("bp_sig_hold", 64'(sig_out), 64'd1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("bp_ready_stays_low", 64'(ready_in), 64'd0);
    end
    @(negedge clk);
    ready_out = 1'b1;
    #1;
    check("bp_release_ready", 64'(ready_in), 64'd1);
    send_beat(3, 0, 0, 0, 0, 4'hF, 5'b0, 1'b1, 32'h13);
    idle();
    wait_drain("drain_backpressure");

    // Reset with a finished result in OUT and a partial group in the accumulator
    @(negedge clk);
    ready_out = 1'b0;
    send_beat(50, 0, 0, 0, 0, 4'hF, 5'b0, 1'b1, 32'h1F);
    send_beat(100, 0, 0, 0, 0, 4'hF, 5'b1, 1'b0, 32'h20);
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_valid_out", 64'(valid_out), 64'd0);
    sb.delete();
    m_first = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ready_out = 1'b1;
    send_beat(1, 0, 0, 0, 0, 4'hF, 5'b0, 1'b1, 32'h21);
    idle();
    wait_drain("drain_after_reset");

    // Largest C-term, then a long group landing on -2^31
    send_beat(0, 0, 0, 0, 32'h1FFFFFF, 4'hF, 5'b0, 1'b1, 32'h30);
    for (int k = 0; k < 16; k++)
      send_beat(-(1 << 25), -(1 << 25), -(1 << 25), -(1 << 25), 0, 4'hF, 5'b0,
                1'(k == 15), 32'h31);
    idle();
    #1;
    @(negedge clk);
    #1;
    check("wrap_sig", 64'(sig_out), 64'h8000_0000);
    wait_drain("drain_wrap");

    // Random groups under random backpressure
    @(posedge clk);
    rand_bp = 1'b1;
    for (int k = 0; k < 60; k++)
      send_beat(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                int'($urandom), 4'($urandom), 5'($urandom),
                1'(k == 59 || $urandom_range(0, 2) == 0), 32'(k + 'h100));
    rand_bp = 1'b0;
    @(negedge clk);
    ready_out = 1'b1;
    valid_in  = 1'b0;
    last_in   = 1'b0;
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
